// File: rtl/vc_dest_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vc_dest_arbiter                                               |
// | Purpose  : Pops words from two virtual-channel FIFOs (VC0/VC1) and routes |
// |            each word to destination FIFO D0 or D1 by header bit DEST_BIT.|
// |            Pops stall while either destination is almost full.           |
// | Ports    : clk, reset (sync, active-high)                                |
// |            empty_vc0/1, data_vc0/1  - VC FIFO status and read data        |
// |            pause_d0/1               - destination almost-full flags       |
// |            pop_vc0/1                - VC read enables (combinational)     |
// |            push_d0/1, data_out      - destination writes (registered)     |
// |            idle                     - no work pending (registered)        |
// | Options  : VC_ARB_ROUND_ROBIN_EN - alternate VCs when both are non-empty |
// |            (default build: strict VC0 priority)                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vc_dest_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic [DATA_WIDTH-1:0] data_vc0,
  input  logic [DATA_WIDTH-1:0] data_vc1,
  input  logic                  pause_d0,
  input  logic                  pause_d1,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  idle
);

  // Pipeline state: pend_q/src_q remember the pop of the previous cycle,
  // whose data appears on data_vcX this cycle.
  logic                  pend_q;
  logic                  src_q;
  logic                  push_d0_q;
  logic                  push_d1_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  idle_q;

  logic                  go_d;
  logic                  pop_any_d;
  logic [DATA_WIDTH-1:0] word_d;

  // Either destination pausing stalls both: the next word's destination is
  // unknown until it has been popped.
  assign go_d = ~reset & ~pause_d0 & ~pause_d1;

`ifdef VC_ARB_ROUND_ROBIN_EN
  logic last_src_q;
  logic sel_vc1_d;

  // With both VCs pending, take the one not served last; otherwise take
  // whichever is non-empty (sel is irrelevant when both are empty).
  always_comb begin
    sel_vc1_d = empty_vc0;
    if (~empty_vc0 & ~empty_vc1) begin
      sel_vc1_d = ~last_src_q;
    end
  end

  assign pop_vc0 = go_d & ~empty_vc0 & ~sel_vc1_d;
  assign pop_vc1 = go_d & ~empty_vc1 &  sel_vc1_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_src_q <= 1'b0;
    end else if (pop_vc0 | pop_vc1) begin
      last_src_q <= pop_vc1;
    end
  end
`else
  assign pop_vc0 = go_d & ~empty_vc0;
  assign pop_vc1 = go_d &  empty_vc0 & ~empty_vc1;
`endif

  assign pop_any_d = pop_vc0 | pop_vc1;
  assign word_d    = src_q ? data_vc1 : data_vc0;

  // A word already popped is always pushed, regardless of pause: thresholds
  // upstream of this block leave room for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      src_q      <= 1'b0;
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      data_out_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      pend_q <= pop_any_d;
      src_q  <= pop_vc1;
      if (pend_q) begin
        data_out_q <= word_d;
        push_d0_q  <= ~word_d[DEST_BIT];
        push_d1_q  <=  word_d[DEST_BIT];
      end else begin
        push_d0_q  <= 1'b0;
        push_d1_q  <= 1'b0;
      end
      idle_q <= empty_vc0 & empty_vc1 & ~pend_q & ~pop_any_d;
    end
  end

  assign push_d0  = push_d0_q;
  assign push_d1  = push_d1_q;
  assign data_out = data_out_q;
  assign idle     = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_dest_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vc_dest_arbiter                                            |
// | Purpose  : Self-checking bench for vc_dest_arbiter (default build).      |
// |            Upstream VC FIFOs are emulated with queues; expected pushes   |
// |            are scheduled by cycle number from the popped words.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_vc_dest_arbiter;
  localparam int DW   = 6;
  localparam int DBIT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          empty_vc0, empty_vc1;
  logic [DW-1:0] data_vc0, data_vc1;
  logic          pause_d0, pause_d1;
  logic          pop_vc0, pop_vc1;
  logic          push_d0, push_d1;
  logic [DW-1:0] data_out;
  logic          idle;

  vc_dest_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(DBIT)) dut (
    .clk(clk), .reset(reset),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .pause_d0(pause_d0), .pause_d1(pause_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .idle(idle)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] sched[int];  // word expected on the push seen after edge ending cycle k
  bit            prev_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // One clock cycle: inputs applied at negedge, pops checked, then registered
  // outputs checked just after the rising edge.
  task automatic do_cycle(input bit rst_in, input bit p0, input bit p1);
    bit go, x0, x1, e0, e1, exp_idle;
    logic [DW-1:0] w;
    reset     = rst_in;
    pause_d0  = p0;
    pause_d1  = p1;
    e0        = (q0.size() == 0);
    e1        = (q1.size() == 0);
    empty_vc0 = e0;
    empty_vc1 = e1;
    #1;
    go = !rst_in && !p0 && !p1;
    x0 = go && !e0;
    x1 = go && e0 && !e1;
    chk("pop_vc0", pop_vc0, x0);
    chk("pop_vc1", pop_vc1, x1);
    w = 'x;
    if (x0) begin w = q0.pop_front(); sched[cyc + 1] = w; end
    if (x1) begin w = q1.pop_front(); sched[cyc + 1] = w; end
    if (rst_in && sched.exists(cyc)) sched.delete(cyc);
    exp_idle = rst_in ? 1'b1 : (e0 && e1 && !x0 && !x1 && !prev_pop);
    prev_pop = x0 || x1;
    @(posedge clk);
    #1;
    // Read data is valid only the cycle after a pop; otherwise it is junk.
    data_vc0 = x0 ? w : DW'($urandom);
    data_vc1 = x1 ? w : DW'($urandom);
    if (sched.exists(cyc)) begin
      chk("push_d0", push_d0, !sched[cyc][DBIT]);
      chk("push_d1", push_d1,  sched[cyc][DBIT]);
      chk("data_out", data_out, sched[cyc]);
      sched.delete(cyc);
    end else begin
      chk("push_d0", push_d0, 1'b0);
      chk("push_d1", push_d1, 1'b0);
    end
    if (rst_in) chk("data_out_rst", data_out, '0);
    chk("idle", idle, exp_idle);
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    bit rst, e0, e1, p0, p1;
    bit x0, x1;
  } pop_vec_t;

  pop_vec_t tbl[12];

  initial begin
    // Pop-decision table, applied combinationally while clk is still low.
    tbl[0]  = '{1,0,0,0,0, 0,0};
    tbl[1]  = '{0,0,0,0,0, 1,0};
    tbl[2]  = '{0,0,1,0,0, 1,0};
    tbl[3]  = '{0,1,0,0,0, 0,1};
    tbl[4]  = '{0,1,1,0,0, 0,0};
    tbl[5]  = '{0,0,0,1,0, 0,0};
    tbl[6]  = '{0,0,0,0,1, 0,0};
    tbl[7]  = '{0,1,0,0,1, 0,0};
    tbl[8]  = '{0,1,0,1,1, 0,0};
    tbl[9]  = '{1,1,0,0,0, 0,0};
    tbl[10] = '{0,0,1,1,0, 0,0};
    tbl[11] = '{1,0,1,0,0, 0,0};
    data_vc0 = '0;
    data_vc1 = '0;
    prev_pop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; empty_vc0 = tbl[i].e0; empty_vc1 = tbl[i].e1;
      pause_d0 = tbl[i].p0; pause_d1 = tbl[i].p1;
      #1;
      chk($sformatf("tbl%0d_pop_vc0", i), pop_vc0, tbl[i].x0);
      chk($sformatf("tbl%0d_pop_vc1", i), pop_vc1, tbl[i].x1);
    end
    reset = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles with VC0 non-empty; then a single word to D0.
    q0.push_back(6'b000011);
    repeat (3) do_cycle(1, 0, 0);
    repeat (4) do_cycle(0, 0, 0);

    // Routing from VC1: D1 then D0, back to back.
    q1.push_back(6'b100101);
    q1.push_back(6'b000111);
    repeat (5) do_cycle(0, 0, 0);

    // Strict priority: VC0, VC0, VC1, VC1.
    q0.push_back(6'b010001); q0.push_back(6'b110010);
    q1.push_back(6'b101011); q1.push_back(6'b001100);
    repeat (7) do_cycle(0, 0, 0);

    // Pause rises the cycle after a pop; the popped word is still pushed.
    q0.push_back(6'b100001); q0.push_back(6'b000010); q0.push_back(6'b100011);
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 1);
    do_cycle(0, 0, 1);
    do_cycle(0, 1, 0);
    repeat (5) do_cycle(0, 0, 0);

    // Reset the cycle after a pop: the in-flight word is dropped.
    q0.push_back(6'b111111);
    do_cycle(0, 0, 0);
    do_cycle(1, 0, 0);
    repeat (3) do_cycle(0, 0, 0);

    // Randomized traffic, pauses and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      bit r, p0, p1;
      if ($urandom_range(0, 99) < 35) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 99) < 35) q1.push_back(DW'($urandom));
      p0 = ($urandom_range(0, 99) < 12);
      p1 = ($urandom_range(0, 99) < 12);
      r  = ($urandom_range(0, 99) < 2);
      do_cycle(r, p0, p1);
    end
    // Drain.
    repeat (40) do_cycle(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
